// File: rtl/eq_hazard_scoreboard_pkg.sv
// ============================================================================
// Module      : eq_hazard_scoreboard_pkg
// Description : Shared types and constants for the ID-stage hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eq_hazard_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    // Writeback info mirrored from one pipeline register.
    typedef struct packed {
        logic                  v;
        logic                  wr;
        logic [REG_ADDR_W-1:0] addr;
        logic                  ld;
    } slot_t;

    localparam slot_t c_empty_slot = '0;

endpackage

`default_nettype wire

// File: rtl/eq_hazard_scoreboard_hazard_slot_match.sv
// ============================================================================
// Module      : hazard_slot_match
// Description : True when a shadow slot will write a source register in use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_slot_match
    import eq_hazard_scoreboard_pkg::*;
(
    input  slot_t                 i_slot,
    input  logic [REG_ADDR_W-1:0] i_src_addr,
    input  logic                  i_uses,
    output logic                  o_match
);

    // The zero register is never written, so it can never be a dependency.
    assign o_match = i_uses && i_slot.v && i_slot.wr &&
                     (i_slot.addr == i_src_addr) && (i_src_addr != ZERO_REG);

endmodule

`default_nettype wire

// File: rtl/eq_hazard_scoreboard.sv
// ============================================================================
// Module      : eq_hazard_scoreboard
// Description : ID-stage hazard unit for branch-equality and load-use stalls.
//               EQ_HAZARD_PERF_CNT_EN adds a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eq_hazard_scoreboard
    import eq_hazard_scoreboard_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pipe_hold_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
    input  logic                  id_uses_rs_i,
    input  logic                  id_uses_rt_i,
    input  logic                  id_is_branch_eq_i,
    input  logic                  id_reg_write_i,
    input  logic [REG_ADDR_W-1:0] id_write_addr_i,
    input  logic                  id_mem_read_i,
    output logic                  stall_o,
    output logic                  ex_bubble_o,
    output logic [31:0]           stall_count_o
);

    slot_t r_exs;
    slot_t r_mems;

    logic [REG_ADDR_W-1:0] w_src_addr [2];
    logic                  w_src_uses [2];
    logic [1:0]            w_exs_hit;
    logic [1:0]            w_mems_hit;
    logic                  w_branch_haz;
    logic                  w_load_use_haz;
    logic                  w_stall;

    assign w_src_addr[0] = id_rs_addr_i;
    assign w_src_addr[1] = id_rt_addr_i;
    assign w_src_uses[0] = id_uses_rs_i;
    assign w_src_uses[1] = id_uses_rt_i;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_src
            hazard_slot_match u_exs_match (
                .i_slot     (r_exs),
                .i_src_addr (w_src_addr[i]),
                .i_uses     (w_src_uses[i]),
                .o_match    (w_exs_hit[i])
            );
            hazard_slot_match u_mems_match (
                .i_slot     (r_mems),
                .i_src_addr (w_src_addr[i]),
                .i_uses     (w_src_uses[i]),
                .o_match    (w_mems_hit[i])
            );
        end
    endgenerate

    // The ID compare only sees EX/MEM forwarding: anything in EX, or a load in MEM, must wait.
    assign w_branch_haz   = id_is_branch_eq_i &&
                            ((|w_exs_hit) || ((|w_mems_hit) && r_mems.ld));
    assign w_load_use_haz = (|w_exs_hit) && r_exs.ld;
    assign w_stall        = id_valid_i && (w_branch_haz || w_load_use_haz);

    assign stall_o     = w_stall;
    assign ex_bubble_o = w_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_exs  <= c_empty_slot;
            r_mems <= c_empty_slot;
        end else if (!pipe_hold_i) begin
            r_mems <= r_exs;
            r_exs  <= w_stall ? c_empty_slot
                              : {id_valid_i, id_reg_write_i, id_write_addr_i, id_mem_read_i};
        end
    end

`ifdef EQ_HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_stall_count <= '0;
        end else if (w_stall && !pipe_hold_i && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count_o = r_stall_count;
`else
    assign stall_count_o = '0;
`endif

endmodule

`default_nettype wire

// File: doc/eq_hazard_scoreboard.md
Name: eq_hazard_scoreboard

Overview:
- Hazard detection unit in the ID stage. Keeps its own shadow copy of the ID/EX and EX/MEM pipeline-register writeback info: valid, write-enable, destination address, is-load.
- Drives the stall that keeps the ID-stage branch-equality compare correct. That compare only receives forwarded data from EX/MEM.
- Also detects load-use hazards for the EX-stage ALU forwarding path.
- Sits upstream of the ID-stage equality forwarding mux and gates the IF/ID and ID/EX pipeline registers.

Parameters:
- REG_ADDR_W, 5, register address width.
- ZERO_REG, 0, hard-wired zero register; never a hazard source.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- pipe_hold_i  in  1  global freeze (e.g. memory wait); no pipeline register advances.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_addr_i  in  REG_ADDR_W  source register rs.
- id_rt_addr_i  in  REG_ADDR_W  source register rt.
- id_uses_rs_i  in  1  instruction reads rs.
- id_uses_rt_i  in  1  instruction reads rt.
- id_is_branch_eq_i  in  1  beq/bne, resolved in ID.
- id_reg_write_i  in  1  ID instruction will write back.
- id_write_addr_i  in  REG_ADDR_W  ID destination register.
- id_mem_read_i  in  1  ID instruction is a load.
- stall_o  out  1  hold PC and IF/ID.
- ex_bubble_o  out  1  load NOP into ID/EX.
- stall_count_o  out  32  stall-cycle counter (optional feature only).

Behaviour:
- Two shadow slots, EXS (mirrors ID/EX) and MEMS (mirrors EX/MEM). Each slot has fields v, wr, addr, ld.
- Reset (rst_n_i=0 at a rising edge): both slots cleared to v=0. stall_o=0, ex_bubble_o=0, stall_count_o=0.
- A reset asserted mid-stall clears everything; stall_o is 0 on the following cycle.
- match(slot, r): slot.v && slot.wr && slot.addr==r && r!=ZERO_REG. Evaluated only for sources whose uses bit is set.
- Branch hazard (id_is_branch_eq_i=1):
  - stall if match(EXS, src): the ALU result is not yet in EX/MEM.
  - stall if match(MEMS, src) && MEMS.ld: load data is not forwardable from EX/MEM.
- Load-use hazard (any instruction): stall if match(EXS, src) && EXS.ld.
- stall_o = id_valid_i && (branch hazard || load-use hazard).
  - Combinational from the registered slots and ID inputs; zero latency.
  - ex_bubble_o = stall_o.
- Slot update on each rising edge, with rst_n_i=1:
  - pipe_hold_i=1: slots keep their values. The hold takes priority over stall_o; stall_o may still read 1.
  - else MEMS <= EXS.
  - else EXS <= stall_o ? empty (v=0) : {id_valid_i, id_reg_write_i, id_write_addr_i, id_mem_read_i}.
- Maximum consecutive stall cycles:
  - 2 for a branch directly after a load into its source register.
  - 1 for a branch after an ALU op, or any load-use case.
- id_valid_i=0: no stall. The slot still shifts, and an empty entry enters EXS.

Optional Feature:
- Macro: EQ_HAZARD_PERF_CNT_EN.
- Defined: stall_count_o increments by 1 on each rising edge where stall_o=1 and pipe_hold_i=0. It saturates at 32'hFFFF_FFFF and clears on reset.
- Undefined: stall_count_o is tied to 0 and no counter flops are built.

Decomposition:
- Shared package holds:
  - REG_ADDR_W and ZERO_REG.
  - the slot record typedef {v, wr, addr, ld}.
  - an empty-slot constant.
- One sub-module is natural: hazard_slot_match. It is combinational and takes slot, source address and uses bit, returning the match result; it is instantiated four times.
- Slot registers and the counter stay in the top module.

Test Plan:
- lw $5 then beq $5,$6 → stall_o=1 for 2 cycles. ex_bubble_o=1 on both. The branch is released on cycle 3, with EXS empty and MEMS empty behind the load.
- add $5 then beq $5,$0 → stall_o=1 for exactly 1 cycle, then 0 once add reaches MEMS (forwardable).
- lw $7 then add $8,$7,$9 → stall_o=1 for 1 cycle. A second case with add $8,$9,$10 (no use of $7) → stall_o=0.
- add $0,... then beq $0,$1 → stall_o=0 (zero register is exempt).
- lw $5 then beq $5, with pipe_hold_i=1 for 3 cycles during the stall → slots frozen and stall_o stays 1 throughout. The hazard then clears after 2 unheld cycles. With the macro defined, stall_count_o=2.
- Reset asserted during a branch stall → next cycle stall_o=0, slots empty, stall_count_o=0.
